// File: rtl/phase_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : phase_accumulator_if
//  Description : Stream bundle around the phase accumulator.
//                - freq   : FTW input stream with valid/ready
//                - offset : phase offset load (valid only, always accepted)
//                - phase  : phase output stream to the DDS (valid only)
//                The slave modport is the accumulator side and the master
//                modport is the driving/consuming side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface phase_accumulator_if #(
   parameter int ACC_DW   = 32,
   parameter int PHASE_DW = 16
);
   logic [ACC_DW-1:0]   s_axis_freq_tdata;
   logic                s_axis_freq_tvalid;
   logic                s_axis_freq_tready;
   logic [ACC_DW-1:0]   s_axis_offset_tdata;
   logic                s_axis_offset_tvalid;
   logic [PHASE_DW-1:0] m_axis_phase_tdata;
   logic                m_axis_phase_tvalid;

   modport slave (
      input  s_axis_freq_tdata,
      input  s_axis_freq_tvalid,
      output s_axis_freq_tready,
      input  s_axis_offset_tdata,
      input  s_axis_offset_tvalid,
      output m_axis_phase_tdata,
      output m_axis_phase_tvalid
   );

   modport master (
      output s_axis_freq_tdata,
      output s_axis_freq_tvalid,
      input  s_axis_freq_tready,
      output s_axis_offset_tdata,
      output s_axis_offset_tvalid,
      input  m_axis_phase_tdata,
      input  m_axis_phase_tvalid
   );
endinterface
`default_nettype wire

// File: rtl/phase_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : phase_accumulator
//  Description : NCO phase generator feeding the sine/cosine DDS stage.
//                Integrates a frequency tuning word every enabled cycle, adds
//                a phase offset and optional LFSR dither, and emits the
//                truncated phase two cycles after each enable.
//  Ports       : clk    - clock
//                reset  - asynchronous active-high reset
//                enable - advance accumulator / emit one sample
//                sync   - synchronous phase clear (also reseeds dither)
//                axis   - freq (valid/ready), offset (valid) and phase
//                         (valid) streams, slave modport
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_accumulator #(
   parameter int PHASE_DW       = 16,
   parameter int ACC_DW         = 32,
   parameter int DITHER_DW      = 0,
   parameter int UPDATE_AT_WRAP = 0
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic          enable,
   input  wire logic          sync,
   phase_accumulator_if.slave axis
);

   localparam logic [31:0] c_lfsr_seed = 32'hACE12468;
   // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] c_lfsr_taps = 32'h80200003;

   logic [ACC_DW-1:0] r_acc;
   logic [ACC_DW-1:0] r_ftw_active;
   logic [ACC_DW-1:0] r_ftw_shadow;
   logic [ACC_DW-1:0] r_offset_active;
   logic [ACC_DW-1:0] r_s1_sum;
   logic              r_pending;
   logic              r_s1_valid;

   logic [ACC_DW-1:0] w_a_cur;
   logic [ACC_DW:0]   w_step;
   logic [ACC_DW-1:0] w_dither;
   logic [ACC_DW-1:0] w_s2;
   logic              w_carry;
   logic              w_accept;
   logic              w_transfer;

   // sync forces the current phase to zero for this cycle's step and sample
   assign w_a_cur  = sync ? '0 : r_acc;
   assign w_step   = {1'b0, w_a_cur} + {1'b0, r_ftw_active};
   assign w_carry  = w_step[ACC_DW];

   assign axis.s_axis_freq_tready = !r_pending && !reset;
   assign w_accept = axis.s_axis_freq_tvalid && axis.s_axis_freq_tready;

   // Immediate mode hands the shadow over on the cycle after acceptance;
   // wrap mode waits for a phase-coherent point (carry-out or sync).
   assign w_transfer = r_pending &&
                       ((UPDATE_AT_WRAP == 0) || (enable && w_carry) || sync);

   assign w_s2 = r_s1_sum + w_dither;

   generate
      if (DITHER_DW > 0) begin : g_dither
         logic [31:0] r_lfsr;

         // Advances once per sample leaving stage 2; sync restarts the
         // sequence so dither is repeatable relative to phase zero.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_lfsr <= c_lfsr_seed;
            end else if (sync) begin
               r_lfsr <= c_lfsr_seed;
            end else if (r_s1_valid) begin
               r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 32'h0);
            end
         end

         assign w_dither = {{(ACC_DW-DITHER_DW){1'b0}}, r_lfsr[DITHER_DW-1:0]};
      end else begin : g_no_dither
         assign w_dither = '0;
      end

      if (ACC_DW > PHASE_DW) begin : g_trunc
         // Bits below the truncation point only matter for carry into the
         // output bits.
         logic w_unused_lsbs;
         assign w_unused_lsbs = ^w_s2[ACC_DW-PHASE_DW-1:0];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc                    <= '0;
         r_ftw_active             <= '0;
         r_ftw_shadow             <= '0;
         r_offset_active          <= '0;
         r_pending                <= 1'b0;
         r_s1_sum                 <= '0;
         r_s1_valid               <= 1'b0;
         axis.m_axis_phase_tdata  <= '0;
         axis.m_axis_phase_tvalid <= 1'b0;
      end else begin
         if (enable) begin
            r_acc <= w_step[ACC_DW-1:0];
         end else if (sync) begin
            r_acc <= '0;
         end

         // Acceptance needs !pending and transfer needs pending, so the two
         // branches never compete.
         if (w_transfer) begin
            r_ftw_active <= r_ftw_shadow;
            r_pending    <= 1'b0;
         end else if (w_accept) begin
            r_ftw_shadow <= axis.s_axis_freq_tdata;
            r_pending    <= 1'b1;
         end

         if (axis.s_axis_offset_tvalid) begin
            r_offset_active <= axis.s_axis_offset_tdata;
         end

         // Stage 1: phase plus offset
         r_s1_valid <= enable;
         if (enable) begin
            r_s1_sum <= w_a_cur + r_offset_active;
         end

         // Stage 2: dither and truncate; data holds between samples
         axis.m_axis_phase_tvalid <= r_s1_valid;
         if (r_s1_valid) begin
            axis.m_axis_phase_tdata <= w_s2[ACC_DW-1 -: PHASE_DW];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_phase_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_accumulator
//  Description : Bench for phase_accumulator. Two instances share stimulus:
//                dut0 = immediate FTW update, no dither
//                dut1 = FTW update at wrap, 4 dither bits
//                A behavioural model predicts every output cycle; directed
//                sections pin the model with literal phase sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_accumulator;

   typedef logic [15:0] seq_t [8];

   localparam logic [31:0] c_seed = 32'hACE12468;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic sync = 1'b0;
   logic f_valid = 1'b0;
   logic [31:0] f_data = '0;
   logic o_valid = 1'b0;
   logic [31:0] o_data = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   phase_accumulator_if #(.ACC_DW(32), .PHASE_DW(16)) ifc0 ();
   phase_accumulator_if #(.ACC_DW(32), .PHASE_DW(16)) ifc1 ();

   assign ifc0.s_axis_freq_tdata    = f_data;
   assign ifc0.s_axis_freq_tvalid   = f_valid;
   assign ifc0.s_axis_offset_tdata  = o_data;
   assign ifc0.s_axis_offset_tvalid = o_valid;
   assign ifc1.s_axis_freq_tdata    = f_data;
   assign ifc1.s_axis_freq_tvalid   = f_valid;
   assign ifc1.s_axis_offset_tdata  = o_data;
   assign ifc1.s_axis_offset_tvalid = o_valid;

   phase_accumulator #(.PHASE_DW(16), .ACC_DW(32), .DITHER_DW(0), .UPDATE_AT_WRAP(0)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .sync(sync), .axis(ifc0.slave));
   phase_accumulator #(.PHASE_DW(16), .ACC_DW(32), .DITHER_DW(4), .UPDATE_AT_WRAP(1)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .sync(sync), .axis(ifc1.slave));

   logic [15:0] d_data  [2];
   logic        d_valid [2];
   logic        d_ready [2];
   assign d_data[0]  = ifc0.m_axis_phase_tdata;
   assign d_data[1]  = ifc1.m_axis_phase_tdata;
   assign d_valid[0] = ifc0.m_axis_phase_tvalid;
   assign d_valid[1] = ifc1.m_axis_phase_tvalid;
   assign d_ready[0] = ifc0.s_axis_freq_tready;
   assign d_ready[1] = ifc1.s_axis_freq_tready;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %h, want %h", name, k, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   int unsigned uaw   [2] = '{0, 1};
   int unsigned dmask [2] = '{32'h0, 32'hF};

   logic [31:0] m_acc [2], m_ftw [2], m_shadow [2], m_off [2], m_lfsr [2];
   logic        m_pend [2];
   // sample taken at the previous edge, still travelling to the output
   logic        m_inflight_v [2];
   logic [31:0] m_inflight_ph [2];
   logic [15:0] e_data [2];
   logic        e_valid [2];

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            m_acc[k] = '0; m_ftw[k] = '0; m_shadow[k] = '0; m_off[k] = '0;
            m_pend[k] = 1'b0; m_lfsr[k] = c_seed;
            m_inflight_v[k] = 1'b0; m_inflight_ph[k] = '0;
            e_data[k] = '0; e_valid[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            logic [32:0] stp;
            logic [31:0] a_cur;
            logic        xfer;
            // output the sample taken one edge ago
            e_valid[k] = m_inflight_v[k];
            if (m_inflight_v[k]) begin
               e_data[k] = 16'((m_inflight_ph[k] + (m_lfsr[k] & dmask[k])) >> 16);
               m_lfsr[k] = lfsr_next(m_lfsr[k]);
            end
            if (sync) m_lfsr[k] = c_seed;
            // take a new sample and step the phase
            a_cur = sync ? 32'h0 : m_acc[k];
            stp   = {1'b0, a_cur} + {1'b0, m_ftw[k]};
            m_inflight_v[k] = enable;
            if (enable) m_inflight_ph[k] = a_cur + m_off[k];
            if (enable) m_acc[k] = stp[31:0];
            else if (sync) m_acc[k] = '0;
            // tuning word handshake
            xfer = m_pend[k] && (uaw[k] == 0 || (enable && stp[32]) || sync);
            if (xfer) begin
               m_ftw[k] = m_shadow[k];
               m_pend[k] = 1'b0;
            end else if (f_valid && !m_pend[k]) begin
               m_shadow[k] = f_data;
               m_pend[k] = 1'b1;
            end
            if (o_valid) m_off[k] = o_data;
         end
      end
   end

   // ---------------------------------------------------- compare + capture
   logic [15:0] cap0 [$];
   logic [15:0] cap1 [$];

   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 2; k++) begin
            chk("tvalid", k, 32'(d_valid[k]), 32'(e_valid[k]));
            chk("tdata",  k, 32'(d_data[k]),  32'(e_data[k]));
            chk("tready", k, 32'(d_ready[k]), 32'(!m_pend[k]));
            if (d_valid[k] === 1'b1) begin
               if (k == 0) cap0.push_back(d_data[k]);
               else        cap1.push_back(d_data[k]);
            end
         end
      end
   end

   function automatic logic [15:0] capget(input int k, input int i);
      if (k == 0) return (i < cap0.size()) ? cap0[i] : 16'hxxxx;
      return (i < cap1.size()) ? cap1[i] : 16'hxxxx;
   endfunction

   task automatic check_seq(input string name, input int k, input int n, input seq_t e);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s[%0d]", name, i), k, 32'(capget(k, i)), 32'(e[i]));
      chk({name, "_count"}, k, (k == 0) ? cap0.size() : cap1.size(), n);
   endtask

   task automatic clear_caps();
      cap0.delete();
      cap1.delete();
   endtask

   // one clock cycle with the given inputs; returns at posedge + 1
   task automatic cyc(input logic en, input logic sy, input logic fv, input logic [31:0] fd,
                      input logic ov, input logic [31:0] od);
      enable = en; sync = sy; f_valid = fv; f_data = fd; o_valid = ov; o_data = od;
      @(posedge clk);
      #1;
      enable = 1'b0; sync = 1'b0; f_valid = 1'b0; o_valid = 1'b0;
   endtask

   task automatic run(input int n, input logic en);
      for (int i = 0; i < n; i++) cyc(en, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_tdata",  k, 32'(d_data[k]),  32'h0);
         chk("rst_tvalid", k, 32'(d_valid[k]), 32'h0);
         chk("rst_tready", k, 32'(d_ready[k]), 32'h0);
      end
      #2 reset = 1'b0;
      @(posedge clk);
      #1;

      // FTW 0x00010000, offset 0
      cyc(1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, '0);
      chk("tready_after_accept", 0, 32'(d_ready[0]), 32'h0);
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
      chk("tready_after_transfer", 0, 32'(d_ready[0]), 32'h1);
      clear_caps();
      run(6, 1'b1);
      run(3, 1'b0);
      for (int k = 0; k < 2; k++)
         check_seq("ramp", k, 6, '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h0, 16'h0});

      // FTW 0x40000000 with enable toggling
      cyc(1'b0, 1'b0, 1'b1, 32'h4000_0000, 1'b0, '0);
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
      clear_caps();
      for (int i = 0; i < 10; i++) run(1, (i % 2) == 0);
      run(3, 1'b0);
      for (int k = 0; k < 2; k++)
         check_seq("quarter", k, 5, '{16'h0, 16'h4000, 16'h8000, 16'hC000, 16'h0, 16'h0, 16'h0, 16'h0});

      // new FTW 0x20000000 written while the phase is at 0x4000
      clear_caps();
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b1, 32'h2000_0000, 1'b0, '0);
      run(5, 1'b1);
      run(3, 1'b0);
      check_seq("update_now", 0, 7,
                '{16'h0, 16'h4000, 16'h8000, 16'hC000, 16'hE000, 16'h0000, 16'h2000, 16'h0});
      check_seq("update_wrap", 1, 7,
                '{16'h0, 16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h2000, 16'h4000, 16'h0});

      // offsets
      cyc(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h8000_0000);
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
      clear_caps();
      run(3, 1'b1);
      run(3, 1'b0);
      for (int k = 0; k < 2; k++)
         check_seq("offset_half", k, 3, '{16'h8000, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
      cyc(1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b1, 32'hFFFF_0000);
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
      clear_caps();
      run(2, 1'b1);
      run(3, 1'b0);
      for (int k = 0; k < 2; k++)
         check_seq("offset_wrap", k, 2, '{16'hFFFF, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});

      // sync with and without enable
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h0);
      clear_caps();
      run(48, 1'b1);
      run(2, 1'b0);
      chk("last_before_sync", 0, 32'(capget(0, 47)), 32'h002F);
      clear_caps();
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      run(3, 1'b0);
      for (int k = 0; k < 2; k++)
         check_seq("sync", k, 3, '{16'h0, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) == 0, $urandom,
             $urandom_range(0, 7) == 0, $urandom);
      end

      // asynchronous reset in the middle of a stream
      cyc(1'b0, 1'b0, 1'b1, 32'h0100_0000, 1'b0, '0);
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
      enable = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("tvalid_before_reset", 0, 32'(d_valid[0]), 32'h1);
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("async_tdata",  k, 32'(d_data[k]),  32'h0);
         chk("async_tvalid", k, 32'(d_valid[k]), 32'h0);
         chk("async_tready", k, 32'(d_ready[k]), 32'h0);
      end
      enable = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      clear_caps();
      run(5, 1'b1);
      run(3, 1'b0);
      for (int k = 0; k < 2; k++)
         check_seq("post_reset", k, 5, '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/phase_accumulator.md
Name: phase_accumulator

Overview:
- Numerically controlled phase generator directly upstream of the sine/cosine DDS stage.
- Integrates a frequency tuning word (FTW) every enabled cycle and adds a phase offset plus optional LFSR dither.
- Truncates the result to PHASE_DW and drives the DDS phase input stream (valid-only, no backpressure).
- FTW updates use a shadow register with valid/ready handshake and are applied immediately or phase-coherently at accumulator wrap.

Parameters:
- PHASE_DW, 16: output phase width; matches DDS phase input.
- ACC_DW, 32: accumulator, FTW and offset width; must be >= PHASE_DW.
- DITHER_DW, 0: LFSR dither bits added below the truncation point; 0 disables dither; must be <= ACC_DW-PHASE_DW.
- UPDATE_AT_WRAP, 0: 0 = pending FTW applies next cycle; 1 = pending FTW applies only on accumulator wrap or sync.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_axis_freq_tdata  in  ACC_DW  new FTW, unsigned
- s_axis_freq_tvalid  in  1  FTW valid
- s_axis_freq_tready  out  1  shadow register free
- s_axis_offset_tdata  in  ACC_DW  phase offset, unsigned
- s_axis_offset_tvalid  in  1  load offset (always accepted)
- enable  in  1  advance accumulator / emit one sample this cycle
- sync  in  1  synchronous phase clear
- m_axis_phase_tdata  out  PHASE_DW  phase to DDS
- m_axis_phase_tvalid  out  1  phase valid

Behaviour:
- Reset (async, active-high) clears all state to 0:
  - acc, ftw_active, offset_active, pending, pipeline registers, m_axis_phase_tdata, m_axis_phase_tvalid.
  - s_axis_freq_tready = 0 while reset is high.
  - LFSR loads seed 32'hACE12468.
- FTW handshake:
  - Accept when tvalid && tready. The word goes to ftw_shadow and pending is set.
  - tready = !pending && !reset. No new word can be accepted while one is pending.
- FTW transfer (ftw_active <= ftw_shadow, pending cleared):
  - UPDATE_AT_WRAP=0: on the cycle after acceptance, regardless of enable.
  - UPDATE_AT_WRAP=1: on a cycle with enable && carry-out of (acc + ftw_active), or on any cycle with sync.
  - The transferred FTW is first used in the step after the transfer cycle.
- Offset: s_axis_offset_tvalid loads offset_active at the clock edge. It is used by samples whose stage 1 occurs after that edge.
- Accumulator (modulo 2^ACC_DW, unsigned wrap):
  - Define a_cur = sync ? 0 : acc.
  - If enable: acc <= a_cur + ftw_active. Otherwise, if sync: acc <= 0. Otherwise acc holds.
  - Wrap = carry-out of a_cur + ftw_active.
- Pipeline, latency 2 cycles from enable to tvalid:
  - Stage 1, on enable: s1_sum <= a_cur + offset_active (mod 2^ACC_DW); s1_valid <= enable.
  - Stage 2: s2 = s1_sum + zero-extended LFSR[DITHER_DW-1:0] (mod 2^ACC_DW). Dither term is 0 when DITHER_DW=0.
  - Stage 2 registers: m_axis_phase_tdata <= s2[ACC_DW-1 -: PHASE_DW]; m_axis_phase_tvalid <= s1_valid.
  - When s1_valid=0, tdata holds its previous value.
- Dither LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - Advances once per stage-2 valid sample.
  - sync reloads the seed.
- Enable may toggle every cycle. Output samples are exactly one per enabled cycle, in order, with no bubbles added.
- sync with enable low: acc cleared; no sample emitted.
- sync with enable high: the emitted sample is phase 0 + offset, and acc becomes ftw_active.
- Reset mid-operation: in-flight samples are discarded. The first post-reset sample appears 2 cycles after the first enable.

Test Plan:
- Reset, FTW=0x00010000 accepted, offset 0, enable held high → tready low 1 cycle after accept; samples 0x0000, 0x0001, 0x0002, … one per cycle, first sample 2 cycles after first enable in which FTW is active.
- FTW=0x40000000 → sequence 0x0000, 0x4000, 0x8000, 0xC000, 0x0000 (wrap); enable toggled 1010… → same sequence, tvalid on alternate cycles only.
- UPDATE_AT_WRAP=1, FTW=0x40000000 running, write 0x20000000 at phase 0x4000 → tready low until the wrap step; outputs 0x8000, 0xC000, 0x0000, 0x2000, 0x4000.
- Offset 0x80000000 loaded with FTW=0 → constant 0x8000; offset 0xFFFF0000 with FTW=0x00010000 → 0xFFFF, 0x0000 (offset wrap correct).
- sync and enable high at phase 0x3000 with FTW 0x00010000 → that sample = 0x0000 (offset 0), next 0x0001; sync with enable low → no tvalid, next enabled sample 0x0000.
- Async reset asserted mid-stream with tvalid high → tdata=0, tvalid=0, tready=0 immediately without a clock edge; after release, acc and ftw_active are 0 (constant 0x0000 output until a new FTW is loaded).
